sop_lut_sweeper: RTL and testbench
==================================

Name: sop_lut_sweeper

Overview:
- Parametrised successor of the fixed 4-input sum-of-products block.
- The boolean function of N inputs is held in a runtime-loadable minterm mask (2^N bits) instead of being hard-wired.
- Provides a registered direct evaluation path and a self-driven sweep that steps through every input combination, emitting one truth-table row per cycle and counting true minterms.
- Used as a reusable function unit and as a self-checking truth-table generator in lab benches.

Parameters:
- N, 4, number of function inputs (2 to 8).
- M, 2**N, derived mask width and number of rows. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  shifts load_bit into the mask this cycle.
- load_bit  input  1  serial mask bit; MSB (minterm M-1) first.
- x  input  N  direct evaluation vector; x[N-1] is the MSB (first variable).
- start  input  1  begins a sweep from IDLE.
- s  output  1  registered function value of x.
- sweep_in  output  N  row index currently presented.
- sweep_out  output  1  function value for sweep_in.
- sweep_valid  output  1  sweep_in/sweep_out hold a valid row.
- busy  output  1  high while state is SWEEP.
- done  output  1  one-cycle pulse after the last row.
- count  output  N+1  number of true minterms found by the last sweep.

Behaviour:
- Reset (async, immediate): mask=0, s=0, state=IDLE, idx=0, sweep_in=0, sweep_out=0, sweep_valid=0, busy=0, done=0, count=0.
- Reset asserted mid-sweep aborts the sweep and clears everything above, including the mask.
- Mask load:
  - Accepted only in IDLE with start=0: mask <= {mask[M-2:0], load_bit}.
  - Ignored in SWEEP and DONE, and ignored when start is accepted in the same cycle (start has priority).
  - After M load cycles, mask[i] = f(row i).
- Direct path: s <= mask[x] every cycle in all states (one-cycle latency). Because the mask is shifted, loading corrupts s transiently; this is legal.
- FSM:
  - IDLE: on start=1 -> SWEEP, idx<=0, count<=0.
  - SWEEP: each cycle sweep_in<=idx, sweep_out<=mask[idx], sweep_valid<=1, count<=count+mask[idx]. If idx==M-1 go to DONE; otherwise idx<=idx+1. start is ignored.
  - DONE: sweep_valid<=0, done=1 for exactly one cycle, then -> IDLE.
- Timing: if start is sampled at edge k, rows 0..M-1 appear after edges k+1..k+M, done is high after edge k+M+1, and sweep_valid is low again at the same point.
- busy is high from after edge k through the last row; it is low in DONE and IDLE.
- count width is N+1, so an all-ones mask gives exactly M with no wrap. count holds its value until the next accepted start.
- idx never exceeds M-1; there is no wrap-around back into SWEEP.
- sweep_in and sweep_out hold their last values when sweep_valid=0.

Test Plan:
- Load mask 16'h08AE MSB-first (minterms 1,2,3,5,7,11, N=4), then pulse start -> 16 consecutive sweep_valid rows, sweep_out=1 exactly at sweep_in=1,2,3,5,7,11; done pulse after row 15; count=6.
- Same mask, direct path: x=4'b0101 -> s=1 one cycle later; x=4'b1100 -> s=0; x=4'b1011 -> s=1.
- Load 16'hFFFF and sweep -> count=5'b10000 (16, no overflow). Load 16'h0000 and sweep -> count=0, done still pulses.
- Mid-sweep (after row 5), drive load_en=1 with load_bit=0 for 4 cycles and pulse start again -> mask unchanged, rows continue 6..15, only one done pulse, count=6.
- Assert reset while sweep_in=9 -> all outputs 0 immediately, mask=0. A subsequent start without reloading gives count=0.
- start=1 and load_en=1 in the same IDLE cycle -> load ignored, sweep uses the prior mask.

Source files
------------

// File: rtl/sop_lut_sweeper.sv
// ============================================================================
// sop_lut_sweeper : runtime-loadable N-input boolean function with a direct
//                   registered lookup path and a self-driven truth-table sweep.
// Revision 1.0
// ============================================================================
`default_nettype none

module sop_lut_sweeper #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic [N-1:0] x,
  input  logic         start,
  output logic         s,
  output logic [N-1:0] sweep_in,
  output logic         sweep_out,
  output logic         sweep_valid,
  output logic         busy,
  output logic         done,
  output logic [N:0]   count
);

  localparam int           M        = 2 ** N;
  localparam logic [N-1:0] LAST_IDX = N'(M - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   mask_q, mask_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           s_q, s_d;
  logic [N-1:0]   sweep_in_q, sweep_in_d;
  logic           sweep_out_q, sweep_out_d;
  logic           sweep_valid_q, sweep_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N:0]     count_q, count_d;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    s_d           = mask_q[x];
    sweep_in_d    = sweep_in_q;
    sweep_out_d   = sweep_out_q;
    sweep_valid_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    count_d       = count_q;

    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous load request
        if (start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
        end else if (load_en) begin
          mask_d = {mask_q[M-2:0], load_bit};
        end
      end

      ST_SWEEP: begin
        sweep_in_d    = idx_q;
        sweep_out_d   = mask_q[idx_q];
        sweep_valid_d = 1'b1;
        busy_d        = 1'b1;
        count_d       = count_q + {{N{1'b0}}, mask_q[idx_q]};
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      s_q           <= 1'b0;
      sweep_in_q    <= '0;
      sweep_out_q   <= 1'b0;
      sweep_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      s_q           <= s_d;
      sweep_in_q    <= sweep_in_d;
      sweep_out_q   <= sweep_out_d;
      sweep_valid_q <= sweep_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      count_q       <= count_d;
    end
  end

  assign s           = s_q;
  assign sweep_in    = sweep_in_q;
  assign sweep_out   = sweep_out_q;
  assign sweep_valid = sweep_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sop_lut_sweeper.sv
// ============================================================================
// tb_sop_lut_sweeper : scoreboard bench for sop_lut_sweeper (N=4).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sop_lut_sweeper;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic       load_bit;
  logic [3:0] x;
  logic       start;
  logic       s;
  logic [3:0] sweep_in;
  logic       sweep_out;
  logic       sweep_valid;
  logic       busy;
  logic       done;
  logic [4:0] count;

  sop_lut_sweeper #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_bit   (load_bit),
    .x          (x),
    .start      (start),
    .s          (s),
    .sweep_in   (sweep_in),
    .sweep_out  (sweep_out),
    .sweep_valid(sweep_valid),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  typedef struct {
    int idx;
    bit val;
  } row_t;

  typedef struct {
    longint due;
    bit     val;
  } s_exp_t;

  row_t   row_q[$];
  int     done_q[$];
  s_exp_t s_q[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    if (!reset) begin
      if (sweep_valid) begin
        if (row_q.size() == 0) begin
          chk("unexpected_row", int'(sweep_in), -1);
        end else begin
          row_t r;
          r = row_q.pop_front();
          chk("row_idx", int'(sweep_in), r.idx);
          chk("row_val", int'(sweep_out), int'(r.val));
          chk("row_busy", int'(busy), 1);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int ec;
          ec = done_q.pop_front();
          chk("done_count", int'(count), ec);
          chk("done_valid_low", int'(sweep_valid), 0);
          chk("done_busy_low", int'(busy), 0);
        end
      end
      if (s_q.size() > 0 && s_q[0].due == cyc) begin
        s_exp_t e;
        e = s_q.pop_front();
        chk("direct_s", int'(s), int'(e.val));
      end
    end
  end

  task automatic load_mask(input logic [15:0] m);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      load_en  = 1'b1;
      load_bit = m[i];
    end
    @(negedge clk);
    load_en  = 1'b0;
    load_bit = 1'b0;
  endtask

  task automatic direct(input logic [3:0] xv, input bit e);
    s_exp_t it;
    @(negedge clk);
    x      = xv;
    it.due = cyc + 1;
    it.val = e;
    s_q.push_back(it);
  endtask

  task automatic push_sweep(input logic [15:0] m, input int ec);
    for (int r = 0; r < 16; r++) begin
      row_t it;
      it.idx = r;
      it.val = m[r];
      row_q.push_back(it);
    end
    done_q.push_back(ec);
  endtask

  task automatic sweep(input logic [15:0] m, input int ec);
    @(negedge clk);
    start = 1'b1;
    push_sweep(m, ec);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_row(input int n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sweep_valid && int'(sweep_in) == n) found = 1'b1;
    end
    if (!found) chk("wait_row_timeout", 0, 1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(negedge clk);
      if (row_q.size() == 0 && done_q.size() == 0 && s_q.size() == 0) empty = 1'b1;
    end
    if (!empty) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    load_en  = 1'b0;
    load_bit = 1'b0;
    x        = 4'd0;
    start    = 1'b0;
    #12;
    chk("rst_s", int'(s), 0);
    chk("rst_valid", int'(sweep_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_sweep_in", int'(sweep_in), 0);
    @(negedge clk);
    reset = 1'b0;

    // minterms 1,2,3,5,7,11
    load_mask(16'h08AE);
    direct(4'b0101, 1'b1);
    direct(4'b1100, 1'b0);
    direct(4'b1011, 1'b1);
    direct(4'b0000, 1'b0);
    sweep(16'h08AE, 6);
    drain();

    load_mask(16'hFFFF);
    sweep(16'hFFFF, 16);
    drain();

    load_mask(16'h0000);
    sweep(16'h0000, 0);
    drain();

    // load and start during a sweep must both be ignored
    load_mask(16'h08AE);
    sweep(16'h08AE, 6);
    wait_row(5);
    for (int i = 0; i < 4; i++) begin
      load_en  = 1'b1;
      load_bit = 1'b0;
      start    = (i == 1);
      @(negedge clk);
    end
    load_en = 1'b0;
    start   = 1'b0;
    drain();
    direct(4'b0110, 1'b0);
    direct(4'b0001, 1'b1);
    drain();

    // asynchronous reset in the middle of a sweep
    sweep(16'h08AE, 6);
    wait_row(9);
    #2;
    reset = 1'b1;
    row_q.delete();
    done_q.delete();
    s_q.delete();
    #1;
    chk("midrst_s", int'(s), 0);
    chk("midrst_sweep_in", int'(sweep_in), 0);
    chk("midrst_sweep_out", int'(sweep_out), 0);
    chk("midrst_valid", int'(sweep_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_count", int'(count), 0);
    @(negedge clk);
    reset = 1'b0;
    direct(4'b0101, 1'b0);
    sweep(16'h0000, 0);
    drain();

    // start and load in the same IDLE cycle: the load is dropped
    @(negedge clk);
    start    = 1'b1;
    load_en  = 1'b1;
    load_bit = 1'b1;
    push_sweep(16'h0000, 0);
    @(negedge clk);
    start    = 1'b0;
    load_en  = 1'b0;
    load_bit = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
